// File: rtl/mct_rd_arbiter.sv
// Two-requester AXI4 read arbiter with an in-order owner-tag FIFO steering R beats to one stream.
// Define MCT_RD_ARB_RR_EN for round-robin grant; otherwise the NFA loader has strict priority.
module mct_rd_arbiter #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 nfa_arvalid_i,
  output logic                                 nfa_arready_o,
  input  logic [C_ADDR_WIDTH-1:0]              nfa_araddr_i,
  input  logic [7:0]                           nfa_arlen_i,
  input  logic                                 qry_arvalid_i,
  output logic                                 qry_arready_o,
  input  logic [C_ADDR_WIDTH-1:0]              qry_araddr_i,
  input  logic [7:0]                           qry_arlen_i,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]              m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]              m_axi_rdata,
  input  logic                                 m_axi_rlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_ttype,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding_o,
  output logic                                 busy_o
);

  localparam int PTR_W = $clog2(C_MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(C_MAX_OUTSTANDING);

  logic                         arvalid_q;
  logic [C_ADDR_WIDTH-1:0]      araddr_q;
  logic [7:0]                   arlen_q;
  logic [CNT_W-1:0]             outstanding_q;
  logic [CNT_W-1:0]             outstanding_d;
  logic [C_MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic                         fifo_empty_s;
  logic                         can_issue_s;
  logic                         nfa_gnt_s;
  logic                         qry_gnt_s;
  logic                         grant_s;
  logic                         pop_s;

  // The tag FIFO occupancy always equals the outstanding burst count.
  assign fifo_empty_s = (outstanding_q == {CNT_W{1'b0}});
  assign can_issue_s  = (~arvalid_q | m_axi_arready) & (outstanding_q < MAX_CNT);

`ifdef MCT_RD_ARB_RR_EN
  logic rr_q;

  // Under contention the requester that did not win last time is served.
  assign nfa_arready_o = can_issue_s & (~qry_arvalid_i | rr_q);
  assign qry_arready_o = can_issue_s & (~nfa_arvalid_i | ~rr_q);

  // Pointer remembers the owner of the most recent grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (grant_s) begin
      rr_q <= qry_gnt_s;
    end else begin
      rr_q <= rr_q;
    end
  end
`else
  assign nfa_arready_o = can_issue_s;
  assign qry_arready_o = can_issue_s & ~nfa_arvalid_i;
`endif

  assign nfa_gnt_s = nfa_arvalid_i & nfa_arready_o;
  assign qry_gnt_s = qry_arvalid_i & qry_arready_o;
  assign grant_s   = nfa_gnt_s | qry_gnt_s;

  assign m_axi_rready  = m_axis_tready & ~fifo_empty_s;
  assign m_axis_tvalid = m_axi_rvalid & ~fifo_empty_s;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = m_axi_rlast;
  assign m_axis_ttype  = tag_q[rd_ptr_q];
  assign pop_s         = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign outstanding_o = outstanding_q;
  assign busy_o        = arvalid_q | ~fifo_empty_s;

  // A grant and a pop in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // AR register slice, tag FIFO and burst counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arvalid_q     <= 1'b0;
      araddr_q      <= {C_ADDR_WIDTH{1'b0}};
      arlen_q       <= 8'd0;
      outstanding_q <= {CNT_W{1'b0}};
      tag_q         <= {C_MAX_OUTSTANDING{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
    end else begin
      if (grant_s) begin
        arvalid_q       <= 1'b1;
        araddr_q        <= nfa_gnt_s ? nfa_araddr_i : qry_araddr_i;
        arlen_q         <= nfa_gnt_s ? nfa_arlen_i : qry_arlen_i;
        tag_q[wr_ptr_q] <= qry_gnt_s;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end else if (m_axi_arready) begin
        arvalid_q <= 1'b0;
      end else begin
        arvalid_q <= arvalid_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      outstanding_q <= outstanding_d;
    end
  end

endmodule
